// File: rtl/intc_route_sequencer.sv
// Route sequencer for the buffer interconnect.
// Accepts route commands (slot <-> module for N beats) into a small FIFO and
// issues them in order to per-slot write-route FSMs and per-module read-route
// FSMs. Each FSM holds its select for the beat count plus a pipeline drain,
// then parks the select on the interconnect's zero-padded input.
//
// state  | meaning
// IDLE   | select parked on the zero input, resource may accept an issue
// ACTIVE | route live, beats counting down, active mask high
// DRAIN  | select held for interconnect pipeline, mask low, done in last cycle
module intc_route_sequencer #(
    parameter int SLOT_NUM   = 20,
    parameter int MODULE_NUM = 20,
    parameter int CMD_DEPTH  = 8,
    parameter int LEN_W      = 16,
    parameter int DRAIN_LAT  = 2,
    parameter int SW         = $clog2(SLOT_NUM),
    parameter int MW         = $clog2(MODULE_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_dir,
    input  logic [SW-1:0]                       cmd_slot,
    input  logic [MW-1:0]                       cmd_module,
    input  logic [LEN_W-1:0]                    cmd_len,
    output logic                                cmd_err,
    output logic [SLOT_NUM-1:0][MW-1:0]         module_select,
    output logic [MODULE_NUM-1:0][SW-1:0]       slot_select,
    output logic [SLOT_NUM-1:0]                 slot_wr_active,
    output logic [MODULE_NUM-1:0]               module_rd_active,
    output logic [SLOT_NUM-1:0]                 slot_done,
    output logic [MODULE_NUM-1:0]               module_done,
    output logic                                busy
);

    localparam int PW    = $clog2(CMD_DEPTH);
    localparam int CNT_W = PW + 1;

    localparam logic [SW:0]        SLOT_LIM   = (SW + 1)'(SLOT_NUM);
    localparam logic [MW:0]        MODULE_LIM = (MW + 1)'(MODULE_NUM);
    localparam logic [MW-1:0]      MSEL_IDLE  = MW'(MODULE_NUM);
    localparam logic [SW-1:0]      SSEL_IDLE  = SW'(SLOT_NUM);
    localparam logic [LEN_W-1:0]   DRAIN_LOAD = LEN_W'(DRAIN_LAT);
    localparam logic [LEN_W-1:0]   ONE        = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } route_state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic             fifo_dir    [CMD_DEPTH];
    logic [SW-1:0]    fifo_slot   [CMD_DEPTH];
    logic [MW-1:0]    fifo_module [CMD_DEPTH];
    logic [LEN_W-1:0] fifo_len    [CMD_DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             cmd_ok;
    logic             push;
    logic             issue;

    logic             head_dir;
    logic [SW-1:0]    head_slot;
    logic [MW-1:0]    head_module;
    logic [LEN_W-1:0] head_len;
    logic             head_target_idle;

    logic [SLOT_NUM-1:0]   wr_idle;
    logic [MODULE_NUM-1:0] rd_idle;
    logic [SLOT_NUM-1:0]   issue_wr;
    logic [MODULE_NUM-1:0] issue_rd;

    assign cmd_ready = (count != CNT_W'(CMD_DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ok    = ({1'b0, cmd_slot} < SLOT_LIM) &&
                       ({1'b0, cmd_module} < MODULE_LIM) &&
                       (cmd_len != '0);
    assign push      = accept && cmd_ok;

    assign head_dir    = fifo_dir[rd_ptr];
    assign head_slot   = fifo_slot[rd_ptr];
    assign head_module = fifo_module[rd_ptr];
    assign head_len    = fifo_len[rd_ptr];

    // Head-of-line: only the head may issue, and only into an idle resource.
    assign head_target_idle = head_dir ? wr_idle[head_slot] : rd_idle[head_module];
    assign issue            = (count != '0) && head_target_idle;

    // FIFO payload storage; no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dir[wr_ptr]    <= cmd_dir;
            fifo_slot[wr_ptr]   <= cmd_slot;
            fifo_module[wr_ptr] <= cmd_module;
            fifo_len[wr_ptr]    <= cmd_len;
        end
    end

    // FIFO pointers, occupancy and the registered reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= accept && !cmd_ok;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign busy = (count != '0) || !(&wr_idle) || !(&rd_idle);

    // ------------------------------------------------------------------
    // Per-slot write-route FSMs (module -> slot)
    // ------------------------------------------------------------------
    for (genvar i = 0; i < SLOT_NUM; i++) begin : g_slot
        route_state_t     state;
        route_state_t     state_nxt;
        logic [LEN_W-1:0] cnt;
        logic [LEN_W-1:0] cnt_nxt;
        logic [MW-1:0]    sel_q;
        logic [MW-1:0]    sel_nxt;
        logic             done_c;

        assign issue_wr[i] = issue && head_dir && (head_slot == SW'(i));

        // State, counter and select registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_IDLE;
                cnt   <= '0;
                sel_q <= MSEL_IDLE;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                sel_q <= sel_nxt;
            end
        end

        // Next state: load beats on issue, then drain count, then park.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            sel_nxt   = sel_q;
            done_c    = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue_wr[i]) begin
                        state_nxt = ST_ACTIVE;
                        cnt_nxt   = head_len;
                        sel_nxt   = head_module;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt == ONE) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == ONE) begin
                        done_c    = 1'b1;
                        state_nxt = ST_IDLE;
                        sel_nxt   = MSEL_IDLE;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    sel_nxt   = MSEL_IDLE;
                end
            endcase
        end

        assign module_select[i]  = sel_q;
        assign slot_wr_active[i] = (state == ST_ACTIVE);
        assign slot_done[i]      = done_c;
        assign wr_idle[i]        = (state == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Per-module read-route FSMs (slot -> module)
    // ------------------------------------------------------------------
    for (genvar j = 0; j < MODULE_NUM; j++) begin : g_module
        route_state_t     state;
        route_state_t     state_nxt;
        logic [LEN_W-1:0] cnt;
        logic [LEN_W-1:0] cnt_nxt;
        logic [SW-1:0]    sel_q;
        logic [SW-1:0]    sel_nxt;
        logic             done_c;

        assign issue_rd[j] = issue && !head_dir && (head_module == MW'(j));

        // State, counter and select registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_IDLE;
                cnt   <= '0;
                sel_q <= SSEL_IDLE;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                sel_q <= sel_nxt;
            end
        end

        // Next state: load beats on issue, then drain count, then park.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            sel_nxt   = sel_q;
            done_c    = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue_rd[j]) begin
                        state_nxt = ST_ACTIVE;
                        cnt_nxt   = head_len;
                        sel_nxt   = head_slot;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt == ONE) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == ONE) begin
                        done_c    = 1'b1;
                        state_nxt = ST_IDLE;
                        sel_nxt   = SSEL_IDLE;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    sel_nxt   = SSEL_IDLE;
                end
            endcase
        end

        assign slot_select[j]      = sel_q;
        assign module_rd_active[j] = (state == ST_ACTIVE);
        assign module_done[j]      = done_c;
        assign rd_idle[j]          = (state == ST_IDLE);
    end

endmodule
